// File: rtl/arb_pkg.sv
// Shared definitions for the quantum round-robin arbiter.
//   state_t   : arbiter FSM states (IDLE, OWN)
//   pick_t    : result of a rotate-priority scan (found flag + index)
//   MAX_N     : largest supported requester count
//   IDX_W     : index width wide enough for MAX_N requesters
//   rr_scan   : first requester with req high, scanning cyclically from start
//   rr_pick   : same scan, starting just after the last-served pointer
package arb_pkg;

  localparam int unsigned MAX_N = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Pointer increment that wraps at n-1 back to 0.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p,
                                                input int unsigned      n);
    return (32'(p) == n - 1) ? '0 : p + IDX_W'(1);
  endfunction

  // Only the lowest n bits of req take part; start must be below n, so a
  // single conditional subtraction is enough to wrap the scan position.
  function automatic pick_t rr_scan(input logic [MAX_N-1:0] req,
                                    input logic [IDX_W-1:0] start,
                                    input int unsigned      n);
    pick_t       r;
    int unsigned k;
    r = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      k = 32'(start) + i;
      if (k >= n) k = k - n;
      if (i < n && !r.found && req[k[IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = k[IDX_W-1:0];
      end
    end
    return r;
  endfunction

  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                    input logic [IDX_W-1:0] last,
                                    input int unsigned      n);
    return rr_scan(req, next_ptr(last, n), n);
  endfunction

endpackage

// File: rtl/rr_pick_next.sv
// Combinational rotate-priority encoder.
//   req   : N-bit request vector (already masked by the caller)
//   start : index scanned first; the scan wraps from N-1 to 0
//   valid : some bit of req is set
//   idx   : first set bit at or after start, cyclically
module rr_pick_next
  import arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [MAX_N-1:0] req_ext;
  logic [IDX_W-1:0] start_ext;
  pick_t            pick;
  logic             unused_idx_hi;

  always_comb begin
    req_ext              = '0;
    req_ext[N-1:0]       = req;
    start_ext            = '0;
    start_ext[IW-1:0]    = start;
  end

  assign pick  = rr_scan(req_ext, start_ext, N);
  assign valid = pick.found;
  assign idx   = pick.idx[IW-1:0];

  // Upper index bits are always zero for N below MAX_N.
  assign unused_idx_hi = &{1'b0, pick.idx};

endmodule

// File: rtl/rr_arbiter_quantum.sv
// Round-robin arbiter with a per-grant time quantum. An owner keeps the grant
// while its request is high, but after HOLD_CYCLES granted cycles it yields to
// the next waiting requester in round-robin order.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   req      : level request per requester, held until served
//   grant    : registered one-hot grant, all-zero when idle
//   grant_id : index of the current owner, 0 when idle
//   busy     : grant is non-zero
//   preempt  : one-cycle pulse when the owner lost the grant to quantum expiry
module rr_arbiter_quantum
  import arb_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned CW          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 preempt
);

  localparam int unsigned IW = $clog2(N);

  state_t        state, state_n;
  logic [IW-1:0] last, last_n;
  logic [IW-1:0] owner_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  grant_n;
  logic          busy_n, preempt_n;

  logic [IW-1:0] base, start;
  logic          win_valid;
  logic [IW-1:0] win_idx;
  logic          owner_req, expired;

  // While owning, the owner is the requester about to become `last` on any
  // hand-over, so the scan starts after it; when idle it starts after `last`.
  assign base      = (state == OWN) ? grant_id : last;
  assign start     = (base == IW'(N - 1)) ? '0 : base + IW'(1);
  assign owner_req = req[grant_id];
  assign expired   = (cnt == CW'(HOLD_CYCLES));

  // The owner's own bit is masked so a pick is always a different requester.
  rr_pick_next #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (req & ~grant),
    .start (start),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n   = state;
    last_n    = last;
    owner_n   = grant_id;
    cnt_n     = cnt;
    preempt_n = 1'b0;

    case (state)
      IDLE: begin
        if (win_valid) begin
          state_n = OWN;
          owner_n = win_idx;
          cnt_n   = CW'(1);
        end
      end
      OWN: begin
        if (!owner_req) begin
          // Release takes priority over a coincident expiry: no preempt.
          last_n = grant_id;
          if (win_valid) begin
            owner_n = win_idx;
            cnt_n   = CW'(1);
          end else begin
            state_n = IDLE;
            owner_n = '0;
            cnt_n   = '0;
          end
        end else if (expired && win_valid) begin
          last_n    = grant_id;
          owner_n   = win_idx;
          cnt_n     = CW'(1);
          preempt_n = 1'b1;
        end else if (expired) begin
          cnt_n = CW'(1);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    grant_n = '0;
    if (state_n == OWN) grant_n[owner_n] = 1'b1;
    busy_n = (state_n == OWN);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= IW'(N - 1);
      grant_id <= '0;
      cnt      <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      grant_id <= owner_n;
      cnt      <= cnt_n;
      grant    <= grant_n;
      busy     <= busy_n;
      preempt  <= preempt_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_quantum.sv
// Self-checking bench for rr_arbiter_quantum (N=4, HOLD_CYCLES=8).
module tb_rr_arbiter_quantum;

  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam int CW   = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         busy;
  logic         preempt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arbiter_quantum #(
    .N           (N),
    .HOLD_CYCLES (HOLD),
    .CW          (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .preempt  (preempt)
  );

  // Reference model: owner index, last-served index, cycles held so far.
  bit m_busy;
  bit m_pre;
  int m_owner;
  int m_last;
  int m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester with req high after position `from`, going round.
  function automatic int rr_next(input logic [N-1:0] r, input int from);
    for (int off = 1; off <= N; off++) begin
      int j;
      j = (from + off) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_pre   = 0;
    m_owner = 0;
    m_last  = N - 1;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    logic [N-1:0] others;
    m_pre = 0;
    if (!m_busy) begin
      if (r != 0) begin
        m_owner = rr_next(r, m_last);
        m_busy  = 1;
        m_cnt   = 1;
      end
    end else begin
      others          = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_last = m_owner;
        if (others != 0) begin
          m_owner = rr_next(others, m_last);
          m_cnt   = 1;
        end else begin
          m_busy  = 0;
          m_owner = 0;
          m_cnt   = 0;
        end
      end else if (m_cnt == HOLD && others != 0) begin
        m_last  = m_owner;
        m_owner = rr_next(others, m_last);
        m_cnt   = 1;
        m_pre   = 1;
      end else begin
        m_cnt = (m_cnt == HOLD) ? 1 : m_cnt + 1;
      end
    end
  endtask

  // Drive req away from the edge, advance one clock, sample 1ns after it.
  task automatic cycle(input logic [N-1:0] r);
    req = r;
    model_step(r);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] eg;
    eg = m_busy ? (32'd1 << m_owner) : 32'd0;
    check({tag, "/grant"}, grant, eg);
    check({tag, "/grant_id"}, grant_id, m_busy ? m_owner : 0);
    check({tag, "/busy"}, busy, m_busy);
    check({tag, "/preempt"}, preempt, m_pre);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    req   = '0;
    @(posedge clk);
    #1;
    check({tag, "/rst_grant"}, grant, 0);
    check({tag, "/rst_busy"}, busy, 0);
    check({tag, "/rst_preempt"}, preempt, 0);
    check({tag, "/rst_id"}, grant_id, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         pre;
  } vec_t;

  vec_t tbl[33];

  initial begin
    logic [N-1:0] r;
    int           waited;

    // Full contention rotation: each owner holds 8 cycles, then hands over.
    for (int e = 1; e <= 33; e++) begin
      tbl[e-1].req   = 4'b1111;
      tbl[e-1].grant = 4'(1 << (((e - 1) / HOLD) % N));
      tbl[e-1].pre   = (e > 1) && ((e - 1) % HOLD == 0);
    end

    model_reset();
    do_reset("rot");
    for (int i = 0; i < 33; i++) begin
      cycle(tbl[i].req);
      check($sformatf("rot%0d/grant", i), grant, tbl[i].grant);
      check($sformatf("rot%0d/preempt", i), preempt, tbl[i].pre);
    end

    // Lone requester keeps the grant across quantum boundaries.
    do_reset("single");
    for (int i = 0; i < 30; i++) begin
      cycle(4'b0100);
      check($sformatf("single%0d/grant", i), grant, 4'b0100);
      check($sformatf("single%0d/preempt", i), preempt, 0);
    end

    // Early release hands over with no idle gap and no preempt.
    do_reset("early");
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0011);
      check($sformatf("early%0d/grant", i), grant, 4'b0001);
    end
    cycle(4'b0010);
    check("early/grant", grant, 4'b0010);
    check("early/preempt", preempt, 0);

    // Release coinciding with expiry: release wins.
    do_reset("relexp");
    cycle(4'b0010);
    check("relexp/first", grant, 4'b0010);
    for (int i = 0; i < HOLD - 1; i++) begin
      cycle(4'b1010);
      check($sformatf("relexp%0d/hold", i), grant, 4'b0010);
    end
    cycle(4'b1000);
    check("relexp/grant", grant, 4'b1000);
    check("relexp/preempt", preempt, 0);

    // Wrap from owner 3 to 0, then on to 2, within the fairness bound.
    do_reset("wrap");
    cycle(4'b1000);
    check("wrap/first", grant, 4'b1000);
    waited = 0;
    for (int k = 1; k <= 32; k++) begin
      cycle(4'b1101);
      waited++;
      if (k == HOLD) begin
        check("wrap/to0_grant", grant, 4'b0001);
        check("wrap/to0_preempt", preempt, 1);
      end
      if (grant[2]) break;
    end
    check("wrap/to2_grant", grant, 4'b0100);
    check("wrap/to2_preempt", preempt, 1);
    check("wrap/wait_le_16", waited <= 2 * HOLD, 1);

    // Asynchronous reset mid-grant, then re-arbitration from last=N-1.
    do_reset("async");
    for (int i = 0; i < 3; i++) cycle(4'b0100);
    check("async/pre_grant", grant, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check("async/grant", grant, 0);
    check("async/busy", busy, 0);
    check("async/grant_id", grant_id, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle(4'b0110);
    check("async/rearb", grant, 4'b0010);

    // Randomized traffic against the reference model.
    do_reset("rand");
    r = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      cycle(r);
      check_model($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_quantum.md
# rr_arbiter_quantum

Round-robin arbiter that shares one resource among N requesters, with a fixed per-grant time quantum. A requester holds the grant while its request stays high, but is preempted after HOLD_CYCLES when any other requester is waiting. It sits in front of the shared resource and drives its one-hot select, and it replaces the hold-until-release arbiter wherever bounded wait time is required.

## Interface
- N, default 4: number of requesters, 2..16.
- HOLD_CYCLES, default 8: maximum consecutive granted cycles while others wait, 1..255.
- CW, default 8: quantum counter width; must satisfy HOLD_CYCLES ≤ 2^CW-1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  level request per requester, held until served.
- grant  out  N  registered one-hot grant, or all-zero when idle.
- grant_id  out  $clog2(N)  index of the current owner; 0 when idle.
- busy  out  1  high when the grant is non-zero.
- preempt  out  1  one-cycle pulse; owner lost its grant because of quantum expiry.

## Operation
- States: IDLE and OWN. Registers: owner index, last-served pointer `last`, quantum counter `cnt`.
- Reset, asynchronous: IDLE, grant=0, grant_id=0, busy=0, preempt=0, cnt=0, last=N-1, so requester 0 has first priority.
- Pick rule: scan the requesters cyclically, starting at `last`+1 and wrapping at N-1 to 0. The first one with req high wins.
- IDLE:
  - When req≠0, pick a winner, enter OWN, load owner and set cnt=1.
  - Otherwise stay in IDLE.
- OWN, evaluated in priority order each cycle:
  1. Owner's req low (release): set last=owner. If any other req is high, grant the pick winner directly with no idle gap and set cnt=1. Otherwise go to IDLE.
  2. Owner's req high, cnt==HOLD_CYCLES, and another req high (expiry): set last=owner, grant the pick winner, set cnt=1 and pulse preempt.
  3. Owner's req high, cnt==HOLD_CYCLES, and no other req (expiry, uncontested): keep the grant and set cnt=1. No preempt.
  4. Otherwise: keep the grant and set cnt=cnt+1.
- A newly granted requester cannot be preempted before it has held the grant for HOLD_CYCLES cycles.
- Release and expiry in the same cycle: release wins and preempt stays 0.
- With HOLD_CYCLES=1 and all requesters active, the grant rotates every cycle, e.g. 0→1→2→3→0.
- Reset asserted mid-grant: outputs clear immediately (asynchronously). After deassertion, the first grant is re-arbitrated from last=N-1.

## Timing
- All outputs come from registers. There is no combinational path from req to any output.
- Latency from request to grant: req rises at edge k while IDLE, grant is valid after edge k+1.
- Release: the owner drops req before edge k; the new grant or idle state is visible after edge k. The old owner therefore sees its grant for exactly the one cycle in which its req was low.
- Quantum: a requester granted after edge k is guaranteed the grant through the cycle after edge k+HOLD_CYCLES-1. If it is preempted, the grant switches at edge k+HOLD_CYCLES.
- preempt is high for exactly the cycle in which the new grant first appears.
- Worst-case wait for a held request: (N-1)·HOLD_CYCLES cycles, plus 1 cycle of latency.
- busy equals |grant.

## Structure
- Shared package `arb_pkg` holds:
  - the state enum (IDLE, OWN);
  - function `rr_pick(req, last)`, which returns the found flag and index;
  - the localparam for index width.
- Sub-module `rr_pick_next`: combinational rotate-priority encoder taking the N-bit req and the start pointer, returning a valid bit and index. It is instantiated once, with start = `last`+1.
- The top level contains the state register, quantum counter, `last` pointer, and output registers. The `rr_pick_next` input excludes the owner's bit (mask req with ~grant) when evaluating preemption.

## Test plan
- Reset with req=4'b1111: after rst_n rises, grant=0001 on the next edge. It then rotates 0001→0010→0100→1000→0001 every 8 cycles, with preempt pulsing at each switch.
- Single requester: hold req=0100 for 30 cycles. grant stays 0100 the whole time, preempt stays 0, and cnt wraps to 1 every 8 cycles.
- Early release with N=4 and req=0011: owner 0 drops req after 3 cycles. grant becomes 0010 on the next edge and preempt stays 0.
- Release and expiry together: owner 1 drops req in the same cycle that cnt=8, with req[3]=1. grant becomes 1000 and preempt stays 0.
- Wrap and fairness: owner is 3, and req 0 and 2 are pending. At expiry grant goes to 0001, then 0100; requester 2 waits no more than 16 cycles.
- Asynchronous reset mid-grant: drop rst_n while grant=0100, mid-clock. grant and busy clear immediately, without waiting for a clock edge. After release, with req=0110, the first grant is 0010.
